elevator_scan_controller: RTL and testbench

Parametrised successor to the building's main-car controller. It serves NUM_FLOORS floors with a latched request register, SCAN (collective) dispatch, timed floor-to-floor travel, a door dwell timer with hold, and a fault lock-out that raises the maintenance alarm. It sits between the hall and car call-button logic and the car drive and door actuators.

---
 rtl/elevator_scan_controller_pkg.sv | 20 ++
 rtl/elevator_scan_controller_if.sv | 32 +++
 rtl/elevator_scan_controller_scan_dir_select.sv | 32 +++
 rtl/elevator_scan_controller.sv | 166 ++++++++++++++++
 tb/tb_elevator_scan_controller.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/elevator_scan_controller_pkg.sv
// Shared elevator types: car state encoding and width helpers.
// FAULT keeps the encoding used by the express-car controller.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MOVE  = 2'd1,
    DOOR  = 2'd2,
    FAULT = 2'd3
  } state_e;

  function automatic int floor_w(input int num_floors);
    return (num_floors > 2) ? $clog2(num_floors) : 1;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/elevator_scan_controller_if.sv
// Call-button inputs and car status outputs of the SCAN controller.
interface elevator_scan_controller_if #(
  parameter int NUM_FLOORS = 10
);
  import elevator_pkg::*;

  localparam int FLOOR_W = floor_w(NUM_FLOORS);

  logic [NUM_FLOORS-1:0] car_call;
  logic [NUM_FLOORS-1:0] hall_call;
  logic                  hold_door;
  logic                  stuck;
  logic                  over_temp;
  logic [FLOOR_W-1:0]    current_floor;
  logic                  dir_up;
  logic                  moving;
  logic                  door_open;
  logic                  arrived;
  logic [NUM_FLOORS-1:0] pending;
  logic                  maintenance_alarm;

  modport master (
    output car_call, hall_call, hold_door, stuck, over_temp,
    input  current_floor, dir_up, moving, door_open, arrived, pending, maintenance_alarm
  );

  modport slave (
    input  car_call, hall_call, hold_door, stuck, over_temp,
    output current_floor, dir_up, moving, door_open, arrived, pending, maintenance_alarm
  );

endinterface

// File: rtl/elevator_scan_controller_scan_dir_select.sv
// Splits pending requests into ahead / behind / at the current floor
// relative to the committed direction, using masks built from a one-hot.
module scan_dir_select #(
  parameter int NUM_FLOORS = 10,
  parameter int FLOOR_W    = 4
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]    current_floor,
  input  logic                  dir_up,
  output logic                  any_ahead,
  output logic                  any_behind,
  output logic                  here
);

  localparam logic [NUM_FLOORS-1:0] FLOOR_ONE = NUM_FLOORS'(1);

  logic [NUM_FLOORS-1:0] at_s;
  logic [NUM_FLOORS-1:0] below_s;
  logic [NUM_FLOORS-1:0] above_s;
  logic                  any_up_s;
  logic                  any_down_s;

  assign at_s       = FLOOR_ONE << current_floor;
  assign below_s    = at_s - FLOOR_ONE;
  assign above_s    = ~(below_s | at_s);
  assign any_up_s   = |(pending & above_s);
  assign any_down_s = |(pending & below_s);
  assign here       = |(pending & at_s);
  assign any_ahead  = dir_up ? any_up_s : any_down_s;
  assign any_behind = dir_up ? any_down_s : any_up_s;

endmodule

// File: rtl/elevator_scan_controller.sv
// SCAN (collective) elevator controller: latched requests, timed travel,
// door dwell with hold, and a fault lock-out raising the maintenance alarm.
module elevator_scan_controller
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS    = 10,
  parameter int TRAVEL_CYCLES = 2,
  parameter int DOOR_CYCLES   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  elevator_scan_controller_if.slave bus
);

  localparam int FLOOR_W = floor_w(NUM_FLOORS);
  localparam int CNT_W   = max_int($clog2(TRAVEL_CYCLES + 1), $clog2(DOOR_CYCLES + 1));
  localparam logic [CNT_W-1:0]      TRAVEL_LAST = CNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [CNT_W-1:0]      DOOR_LAST   = CNT_W'(DOOR_CYCLES - 1);
  localparam logic [CNT_W-1:0]      CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0]      CNT_ZERO    = CNT_W'(0);
  localparam logic [FLOOR_W-1:0]    FLOOR_STEP  = FLOOR_W'(1);
  localparam logic [NUM_FLOORS-1:0] FLOOR_ONE   = NUM_FLOORS'(1);

  state_e                state_r, state_nx;
  logic [FLOOR_W-1:0]    floor_r, floor_nx;
  logic                  dir_up_r, dir_nx;
  logic [CNT_W-1:0]      travel_cnt_r, travel_nx;
  logic [CNT_W-1:0]      door_cnt_r, door_nx;
  logic [NUM_FLOORS-1:0] pending_r, pending_nx;
  logic                  arrived_r, arrived_nx;
  logic                  moving_r, door_open_r, alarm_r;

  logic [NUM_FLOORS-1:0] calls_s, here_bit_s, step_bit_s, latch_mask_s, clear_s;
  logic [FLOOR_W-1:0]    step_floor_s;
  logic                  call_here_s, fault_s;
  logic                  any_ahead_s, any_behind_s, here_s;

  scan_dir_select #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_dir (
    .pending       (pending_r),
    .current_floor (floor_r),
    .dir_up        (dir_up_r),
    .any_ahead     (any_ahead_s),
    .any_behind    (any_behind_s),
    .here          (here_s)
  );

  assign calls_s      = bus.car_call | bus.hall_call;
  assign here_bit_s   = FLOOR_ONE << floor_r;
  assign call_here_s  = |(calls_s & here_bit_s);
  assign fault_s      = bus.stuck | bus.over_temp;
  assign step_floor_s = dir_up_r ? (floor_r + FLOOR_STEP) : (floor_r - FLOOR_STEP);
  assign step_bit_s   = FLOOR_ONE << step_floor_s;
  // A press at the floor where the car stands opens the door rather than queuing.
  assign latch_mask_s = ((state_r == IDLE) || (state_r == DOOR)) ? ~here_bit_s
                                                                 : {NUM_FLOORS{1'b1}};
  assign pending_nx   = (pending_r | (calls_s & latch_mask_s)) & ~clear_s;

  // Next-state, floor, direction and counter decisions.
  always_comb begin
    state_nx   = state_r;
    floor_nx   = floor_r;
    dir_nx     = dir_up_r;
    travel_nx  = travel_cnt_r;
    door_nx    = door_cnt_r;
    arrived_nx = 1'b0;
    clear_s    = {NUM_FLOORS{1'b0}};
    if (fault_s) begin
      state_nx  = FAULT;
      travel_nx = CNT_ZERO;
      door_nx   = CNT_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          if (call_here_s || here_s) begin
            state_nx = DOOR;
            door_nx  = CNT_ZERO;
            clear_s  = here_bit_s;
          end else if (any_ahead_s) begin
            state_nx  = MOVE;
            travel_nx = CNT_ZERO;
          end else if (any_behind_s) begin
            dir_nx    = ~dir_up_r;
            state_nx  = MOVE;
            travel_nx = CNT_ZERO;
          end else begin
            state_nx = IDLE;
          end
        end
        MOVE: begin
          if (travel_cnt_r == TRAVEL_LAST) begin
            floor_nx  = step_floor_s;
            travel_nx = CNT_ZERO;
            // The stepped-to floor is clear here, so "ahead of it" equals "ahead of us".
            if (|(pending_r & step_bit_s)) begin
              clear_s    = step_bit_s;
              arrived_nx = 1'b1;
              state_nx   = DOOR;
              door_nx    = CNT_ZERO;
            end else if (any_ahead_s) begin
              state_nx = MOVE;
            end else begin
              state_nx = IDLE;
            end
          end else begin
            travel_nx = travel_cnt_r + CNT_ONE;
          end
        end
        DOOR: begin
          if (bus.hold_door || call_here_s) begin
            door_nx = CNT_ZERO;
          end else if (door_cnt_r == DOOR_LAST) begin
            state_nx = IDLE;
            door_nx  = CNT_ZERO;
          end else begin
            door_nx = door_cnt_r + CNT_ONE;
          end
        end
        FAULT: begin
          state_nx = IDLE;
        end
        default: begin
          state_nx = IDLE;
        end
      endcase
    end
  end

  // State, position, request and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      floor_r      <= {FLOOR_W{1'b0}};
      dir_up_r     <= 1'b1;
      travel_cnt_r <= CNT_ZERO;
      door_cnt_r   <= CNT_ZERO;
      pending_r    <= {NUM_FLOORS{1'b0}};
      arrived_r    <= 1'b0;
      moving_r     <= 1'b0;
      door_open_r  <= 1'b0;
      alarm_r      <= 1'b0;
    end else begin
      state_r      <= state_nx;
      floor_r      <= floor_nx;
      dir_up_r     <= dir_nx;
      travel_cnt_r <= travel_nx;
      door_cnt_r   <= door_nx;
      pending_r    <= pending_nx;
      arrived_r    <= arrived_nx;
      moving_r     <= (state_nx == MOVE);
      door_open_r  <= (state_nx == DOOR);
      alarm_r      <= (state_nx == FAULT);
    end
  end

  assign bus.current_floor     = floor_r;
  assign bus.dir_up            = dir_up_r;
  assign bus.moving            = moving_r;
  assign bus.door_open         = door_open_r;
  assign bus.arrived           = arrived_r;
  assign bus.pending           = pending_r;
  assign bus.maintenance_alarm = alarm_r;

endmodule

// File: tb/tb_elevator_scan_controller.sv
// Self-checking bench: directed scenarios plus random traffic, every cycle
// compared with a request-list model of the SCAN rules (10- and 16-floor cars).
module tb_elevator_scan_controller;

  localparam int NF   = 10;
  localparam int NF_B = 16;
  localparam int TC   = 2;
  localparam int DC   = 4;

  localparam int PH_STANDING = 0;
  localparam int PH_TRAVEL   = 1;
  localparam int PH_DOORS    = 2;
  localparam int PH_LOCKED   = 3;

  typedef struct {
    int        floor;
    bit        up;
    int        phase;
    int        left;
    bit [15:0] req;
    bit        arr;
  } model_t;

  logic clk = 1'b0;
  logic reset;
  int   tests_run = 0;
  int   failed    = 0;
  model_t ma, mb;
  logic [24:0] rst_vec;

  always #5 clk = ~clk;

  elevator_scan_controller_if #(.NUM_FLOORS(NF))   bus();
  elevator_scan_controller_if #(.NUM_FLOORS(NF_B)) bus_b();

  elevator_scan_controller #(.NUM_FLOORS(NF), .TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  elevator_scan_controller #(.NUM_FLOORS(NF_B), .TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b)
  );

  function automatic bit any_beyond(bit [15:0] req, int f, bit up, int n);
    for (int i = 0; i < n; i++)
      if (req[i] && (up ? (i > f) : (i < f))) return 1'b1;
    return 1'b0;
  endfunction

  // One clock of the car as described by its rules, using countdowns of remaining cycles.
  function automatic model_t step(model_t m, int n, bit [15:0] calls, bit hold, bit flt, bit rst);
    model_t r = m;
    bit here_call = calls[m.floor];
    int nf;
    r.arr = 1'b0;
    if (rst) begin
      r.floor = 0; r.up = 1'b1; r.phase = PH_STANDING; r.left = 0; r.req = '0;
      return r;
    end
    for (int f = 0; f < n; f++)
      if (calls[f] && !(f == m.floor && (m.phase == PH_STANDING || m.phase == PH_DOORS)))
        r.req[f] = 1'b1;
    if (flt) begin
      r.phase = PH_LOCKED; r.left = 0;
      return r;
    end
    case (m.phase)
      PH_STANDING: begin
        if (here_call || m.req[m.floor]) begin
          r.phase = PH_DOORS; r.left = DC; r.req[m.floor] = 1'b0;
        end else if (any_beyond(m.req, m.floor, m.up, n)) begin
          r.phase = PH_TRAVEL; r.left = TC;
        end else if (any_beyond(m.req, m.floor, !m.up, n)) begin
          r.up = !m.up; r.phase = PH_TRAVEL; r.left = TC;
        end
      end
      PH_TRAVEL: begin
        r.left = m.left - 1;
        if (r.left == 0) begin
          nf = m.up ? m.floor + 1 : m.floor - 1;
          r.floor = nf;
          if (m.req[nf]) begin
            r.req[nf] = 1'b0; r.arr = 1'b1; r.phase = PH_DOORS; r.left = DC;
          end else if (any_beyond(m.req, nf, m.up, n)) begin
            r.left = TC;
          end else begin
            r.phase = PH_STANDING;
          end
        end
      end
      PH_DOORS: begin
        if (hold || here_call) r.left = DC;
        else begin
          r.left = m.left - 1;
          if (r.left == 0) r.phase = PH_STANDING;
        end
      end
      default: r.phase = PH_STANDING;
    endcase
    return r;
  endfunction

  function automatic logic [24:0] exp_vec(model_t m);
    return {4'(m.floor), m.up, (m.phase == PH_TRAVEL), (m.phase == PH_DOORS), m.arr,
            (m.phase == PH_LOCKED), m.req};
  endfunction

  function automatic logic [24:0] obs_a();
    return {4'(bus.current_floor), bus.dir_up, bus.moving, bus.door_open, bus.arrived,
            bus.maintenance_alarm, 16'(bus.pending)};
  endfunction

  function automatic logic [24:0] obs_b();
    return {4'(bus_b.current_floor), bus_b.dir_up, bus_b.moving, bus_b.door_open, bus_b.arrived,
            bus_b.maintenance_alarm, 16'(bus_b.pending)};
  endfunction

  task automatic tick();
    @(posedge clk);
    ma = step(ma, NF, 16'(bus.car_call | bus.hall_call), bus.hold_door,
              bus.stuck | bus.over_temp, reset);
    mb = step(mb, NF_B, 16'(bus_b.car_call | bus_b.hall_call), bus_b.hold_door,
              bus_b.stuck | bus_b.over_temp, reset);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    tests_run++;
    if (obs_a() !== rst_vec) begin
      failed++; $display("FAIL reset_values: got %h expected %h", obs_a(), rst_vec);
    end
    tests_run++;
    if (obs_b() !== rst_vec) begin
      failed++; $display("FAIL reset_values_16: got %h expected %h", obs_b(), rst_vec);
    end
    reset = 1'b0;
    tick();
    tests_run++;
    if (obs_a() !== exp_vec(ma)) begin
      failed++; $display("FAIL reset_idle: got %h expected %h", obs_a(), exp_vec(ma));
    end
  endtask

  task automatic test_single_call();
    int first_move = -1, arrive_at = -1, arr_cnt = 0, door_cyc = 0;
    bus.car_call[5] = 1'b1;
    tick();
    bus.car_call = '0;
    for (int i = 0; i < 40; i++) begin
      tick();
      tests_run++;
      if (obs_a() !== exp_vec(ma)) begin
        failed++; $display("FAIL single_call cyc %0d: got %h expected %h", i, obs_a(), exp_vec(ma));
      end
      if (bus.moving && first_move < 0) first_move = i;
      if (bus.arrived) begin arr_cnt++; arrive_at = i; end
      if (bus.door_open) door_cyc++;
      else if (door_cyc > 0) break;
    end
    // Moving on the first clock after the call is visible; five floors at two clocks each.
    tests_run++;
    if (first_move !== 0 || arrive_at !== 10) begin
      failed++; $display("FAIL single_call_timing: got move %0d arrive %0d expected 0 and 10", first_move, arrive_at);
    end
    tests_run++;
    if (arr_cnt !== 1 || door_cyc !== DC || bus.current_floor !== 4'd5 || bus.pending !== '0) begin
      failed++; $display("FAIL single_call_result: got arrived %0d door %0d floor %0d pending %h expected 1 4 5 0",
                         arr_cnt, door_cyc, bus.current_floor, bus.pending);
    end
  endtask

  task automatic test_reverse();
    int stops[$];
    bit dirs[$];
    bus.car_call[7]  = 1'b1;
    bus.hall_call[2] = 1'b1;
    tick();
    bus.car_call = '0; bus.hall_call = '0;
    for (int i = 0; i < 60; i++) begin
      tick();
      tests_run++;
      if (obs_a() !== exp_vec(ma)) begin
        failed++; $display("FAIL reverse cyc %0d: got %h expected %h", i, obs_a(), exp_vec(ma));
      end
      if (bus.arrived) begin stops.push_back(int'(bus.current_floor)); dirs.push_back(bus.dir_up); end
      if (stops.size() == 2 && !bus.door_open && !bus.moving) break;
    end
    tests_run++;
    if (stops.size() != 2 || stops[0] != 7 || stops[1] != 2 || dirs[1] !== 1'b0) begin
      failed++; $display("FAIL reverse_stops: got %0d stops first %0d expected 7 then 2 going down",
                         stops.size(), (stops.size() > 0) ? stops[0] : -1);
    end
  endtask

  task automatic test_hold();
    int tail = 0;
    bit opened = 1'b0;
    bus.car_call[3] = 1'b1;
    tick();
    bus.car_call = '0;
    for (int i = 0; i < 20 && !opened; i++) begin
      tick();
      tests_run++;
      if (obs_a() !== exp_vec(ma)) begin
        failed++; $display("FAIL hold_approach cyc %0d: got %h expected %h", i, obs_a(), exp_vec(ma));
      end
      opened = bus.door_open;
    end
    tests_run++;
    if (!opened || bus.current_floor !== 4'd3) begin
      failed++; $display("FAIL hold_arrive: got open %0d floor %0d expected 1 at 3", opened, bus.current_floor);
    end
    for (int h = 0; h < 3; h++) begin
      bus.hall_call[3] = 1'b1;
      bus.hold_door    = 1'b1;
      tick();
      tests_run++;
      if (bus.pending[3] !== 1'b0 || bus.door_open !== 1'b1) begin
        failed++; $display("FAIL hold_latch: got pending3 %0d door %0d expected 0 1", bus.pending[3], bus.door_open);
      end
    end
    bus.hall_call = '0;
    bus.hold_door = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      tests_run++;
      if (obs_a() !== exp_vec(ma)) begin
        failed++; $display("FAIL hold_tail cyc %0d: got %h expected %h", i, obs_a(), exp_vec(ma));
      end
      if (bus.door_open) tail++;
      else break;
    end
    // The last hold cycle is the first of the four open cycles that follow it.
    tests_run++;
    if (tail !== DC - 1) begin
      failed++; $display("FAIL hold_dwell: got %0d extra open cycles expected %0d", tail, DC - 1);
    end
  endtask

  task automatic test_fault();
    int stops[$];
    bit between = 1'b0;
    bus.car_call[9] = 1'b1;
    tick();
    bus.car_call = '0;
    for (int i = 0; i < 30 && !between; i++) begin
      tick();
      between = bus.moving && (bus.current_floor == 4'd4);
    end
    tests_run++;
    if (!between) begin
      failed++; $display("FAIL fault_reach: got floor %0d moving %0d expected 4 moving", bus.current_floor, bus.moving);
    end
    bus.stuck = 1'b1;
    tick();
    tests_run++;
    if (bus.maintenance_alarm !== 1'b1 || bus.moving !== 1'b0 || bus.current_floor !== 4'd4) begin
      failed++; $display("FAIL fault_entry: got alarm %0d moving %0d floor %0d expected 1 0 4",
                         bus.maintenance_alarm, bus.moving, bus.current_floor);
    end
    bus.car_call[8] = 1'b1;
    tick();
    bus.car_call = '0;
    tests_run++;
    if (bus.pending[8] !== 1'b1 || obs_a() !== exp_vec(ma)) begin
      failed++; $display("FAIL fault_latch: got %h expected %h", obs_a(), exp_vec(ma));
    end
    tick();
    bus.stuck = 1'b0;
    tick();
    tests_run++;
    if (bus.maintenance_alarm !== 1'b0 || obs_a() !== exp_vec(ma)) begin
      failed++; $display("FAIL fault_exit: got %h expected %h", obs_a(), exp_vec(ma));
    end
    for (int i = 0; i < 60; i++) begin
      tick();
      tests_run++;
      if (obs_a() !== exp_vec(ma)) begin
        failed++; $display("FAIL fault_resume cyc %0d: got %h expected %h", i, obs_a(), exp_vec(ma));
      end
      if (bus.arrived) stops.push_back(int'(bus.current_floor));
      if (stops.size() == 2 && !bus.door_open) break;
    end
    tests_run++;
    if (stops.size() != 2 || stops[0] != 8 || stops[1] != 9) begin
      failed++; $display("FAIL fault_service: got %0d stops expected 8 then 9", stops.size());
    end
  endtask

  task automatic test_top_floor();
    int top_stop = -1, bottom_stop = -1;
    bit down_dir = 1'b1, seen_move = 1'b0;
    bus_b.car_call[15] = 1'b1;
    tick();
    bus_b.car_call = '0;
    for (int i = 0; i < 60; i++) begin
      tick();
      tests_run++;
      if (obs_b() !== exp_vec(mb)) begin
        failed++; $display("FAIL top_up cyc %0d: got %h expected %h", i, obs_b(), exp_vec(mb));
      end
      if (bus_b.arrived) top_stop = int'(bus_b.current_floor);
      if (top_stop >= 0 && !bus_b.door_open) break;
    end
    bus_b.car_call[0] = 1'b1;
    tick();
    bus_b.car_call = '0;
    for (int i = 0; i < 60; i++) begin
      tick();
      tests_run++;
      if (obs_b() !== exp_vec(mb)) begin
        failed++; $display("FAIL top_down cyc %0d: got %h expected %h", i, obs_b(), exp_vec(mb));
      end
      if (bus_b.moving && !seen_move) begin seen_move = 1'b1; down_dir = bus_b.dir_up; end
      if (bus_b.arrived) bottom_stop = int'(bus_b.current_floor);
      if (bottom_stop >= 0 && !bus_b.door_open) break;
    end
    tests_run++;
    if (top_stop != 15 || bottom_stop != 0 || down_dir !== 1'b0) begin
      failed++; $display("FAIL top_reverse: got top %0d bottom %0d dir %0d expected 15 0 0",
                         top_stop, bottom_stop, down_dir);
    end
  endtask

  task automatic test_reset_mid_move();
    bit started = 1'b0;
    bus.car_call[2] = 1'b1;
    tick();
    bus.car_call = '0;
    for (int i = 0; i < 10 && !started; i++) begin
      tick();
      started = bus.moving;
    end
    bus.car_call[6] = 1'b1;
    bus.car_call[9] = 1'b1;
    tick();
    bus.car_call = '0;
    tests_run++;
    if (!started || bus.pending[6] !== 1'b1 || bus.pending[9] !== 1'b1) begin
      failed++; $display("FAIL midmove_setup: got moving %0d pending %h expected moving with 6 and 9",
                         started, bus.pending);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests_run++;
    if (obs_a() !== rst_vec || obs_a() !== exp_vec(ma)) begin
      failed++; $display("FAIL midmove_reset: got %h expected %h", obs_a(), rst_vec);
    end
  endtask

  task automatic test_random();
    int stuck_left = 0;
    for (int c = 0; c < 1500; c++) begin
      bus.car_call  = '0; bus.hall_call  = '0;
      bus_b.car_call = '0; bus_b.hall_call = '0;
      if ($urandom_range(0, 5) == 0) bus.car_call[$urandom_range(0, NF - 1)] = 1'b1;
      if ($urandom_range(0, 7) == 0) bus.hall_call[$urandom_range(0, NF - 1)] = 1'b1;
      if ($urandom_range(0, 5) == 0) bus_b.car_call[$urandom_range(0, NF_B - 1)] = 1'b1;
      if ($urandom_range(0, 7) == 0) bus_b.hall_call[$urandom_range(0, NF_B - 1)] = 1'b1;
      bus.hold_door   = ($urandom_range(0, 9) == 0);
      bus_b.hold_door = ($urandom_range(0, 9) == 0);
      if (stuck_left > 0) stuck_left--;
      else if ($urandom_range(0, 79) == 0) stuck_left = $urandom_range(1, 4);
      bus.stuck       = (stuck_left > 0);
      bus.over_temp   = ($urandom_range(0, 149) == 0);
      bus_b.stuck     = ($urandom_range(0, 99) == 0);
      bus_b.over_temp = 1'b0;
      reset           = ($urandom_range(0, 399) == 0);
      tick();
      tests_run++;
      if (obs_a() !== exp_vec(ma)) begin
        failed++; $display("FAIL random_10 cyc %0d: got %h expected %h", c, obs_a(), exp_vec(ma));
      end
      tests_run++;
      if (obs_b() !== exp_vec(mb)) begin
        failed++; $display("FAIL random_16 cyc %0d: got %h expected %h", c, obs_b(), exp_vec(mb));
      end
    end
    reset = 1'b0;
    bus.car_call = '0; bus.hall_call = '0; bus.hold_door = 1'b0; bus.stuck = 1'b0; bus.over_temp = 1'b0;
    bus_b.car_call = '0; bus_b.hall_call = '0; bus_b.hold_door = 1'b0; bus_b.stuck = 1'b0;
  endtask

  initial begin
    rst_vec = {4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    reset = 1'b1;
    bus.car_call = '0; bus.hall_call = '0; bus.hold_door = 1'b0; bus.stuck = 1'b0; bus.over_temp = 1'b0;
    bus_b.car_call = '0; bus_b.hall_call = '0; bus_b.hold_door = 1'b0;
    bus_b.stuck = 1'b0; bus_b.over_temp = 1'b0;
    test_reset();
    test_single_call();
    test_reverse();
    test_hold();
    test_fault();
    test_top_floor();
    test_reset_mid_move();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of run expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
